// File: rtl/i2c_dac_pkg.sv
// Constants and types shared by the I2C DAC responder and the DAC-side master,
// so both ends agree on addressing, command and code width.
package i2c_dac_pkg;

  localparam logic [7:0] SLAVE_ADDR_DEF    = 8'hC0;
  localparam logic [7:0] CMD_WRITE_DAC_DEF = 8'h40;
  localparam int         SYNC_STAGES_DEF   = 2;
  localparam int         DAC_W             = 12;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_A_ACK     = 4'd2,
    ST_CMD       = 4'd3,
    ST_C_ACK     = 4'd4,
    ST_MSB       = 4'd5,
    ST_M_ACK     = 4'd6,
    ST_LSB       = 4'd7,
    ST_L_ACK     = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_e;

  // The DAC code keeps the full MSB byte and the top nibble of the LSB byte.
  function automatic logic [DAC_W-1:0] dac_code(input logic [7:0] msb,
                                                 input logic [3:0] lsb_hi);
    return {msb, lsb_hi};
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the system clock domain and derives SCL edges and
// START/STOP conditions from the synced values and one history flop.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_hist_q;
  logic                   sda_hist_q;
  logic                   scl_s;
  logic                   sda_s;

  // Reset to the idle bus level so no spurious edge is seen after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign sda_o       = sda_s;
  assign scl_rise_o  = scl_s & ~scl_hist_q;
  assign scl_fall_o  = ~scl_s & scl_hist_q;
  // SCL must be high in both samples so an SDA move next to an SCL edge is not a condition.
  assign start_det_o = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_det_o  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

// File: rtl/i2c_dac_responder.sv
// I2C target that decodes the [ADDR, CMD, MSB, LSB] DAC write frame and
// presents the 12-bit code with a one-cycle DAC_VALID strobe.
module i2c_dac_responder
  import i2c_dac_pkg::*;
#(
  parameter logic [7:0] SLAVE_ADDR    = SLAVE_ADDR_DEF,
  parameter logic [7:0] CMD_WRITE_DAC = CMD_WRITE_DAC_DEF,
  parameter int         SYNC_STAGES   = SYNC_STAGES_DEF
) (
  input  logic             CLOCK_50,
  input  logic             iRST_N,
  input  logic             I2C_SCLK,
  inout  wire              I2C_SDAT,
  output logic [DAC_W-1:0] DAC_CODE,
  output logic             DAC_VALID,
  output logic             FRAME_ERR,
  output logic             BUSY,
  output state_e           DBG_STATE
);

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk_i       (CLOCK_50),
    .rst_ni      (iRST_N),
    .scl_i       (I2C_SCLK),
    .sda_i       (I2C_SDAT),
    .sda_o       (sda_s),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det)
  );

  state_e           state_q,    state_d;
  logic [2:0]       bit_cnt_q,  bit_cnt_d;
  logic             bit_pend_q, bit_pend_d;
  logic [7:0]       shift_q,    shift_d;
  logic [7:0]       msb_q,      msb_d;
  logic             sda_oe_q,   sda_oe_d;
  logic             extra_q,    extra_d;
  logic             busy_q,     busy_d;
  logic [DAC_W-1:0] code_q,     code_d;
  logic             valid_q,    valid_d;
  logic             ferr_q,     ferr_d;

  logic byte_st;
  logic ack_st;
  logic rx_st;

  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd7;
      bit_pend_q <= 1'b0;
      shift_q    <= 8'h00;
      msb_q      <= 8'h00;
      sda_oe_q   <= 1'b0;
      extra_q    <= 1'b0;
      busy_q     <= 1'b0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_pend_q <= bit_pend_d;
      shift_q    <= shift_d;
      msb_q      <= msb_d;
      sda_oe_q   <= sda_oe_d;
      extra_q    <= extra_d;
      busy_q     <= busy_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  assign byte_st = (state_q == ST_ADDR) || (state_q == ST_CMD) ||
                   (state_q == ST_MSB)  || (state_q == ST_LSB);
  assign ack_st  = (state_q == ST_A_ACK) || (state_q == ST_C_ACK) ||
                   (state_q == ST_M_ACK) || (state_q == ST_L_ACK);
  // After a complete frame, trailing bytes are still clocked in so each can be flagged.
  assign rx_st   = byte_st || ((state_q == ST_WAIT_STOP) && extra_q);

  // A bit is counted on the SCL fall that closes it, so the SCL high phase
  // that carries a START/STOP never advances the counter.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_pend_d = bit_pend_q;
    shift_d    = shift_q;
    msb_d      = msb_q;
    sda_oe_d   = sda_oe_q;
    extra_d    = extra_q;
    busy_d     = busy_q;
    code_d     = code_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;

    if (start_det || stop_det) begin
      if (byte_st && (bit_cnt_q != 3'd7)) begin
        ferr_d = 1'b1;
      end
      state_d    = start_det ? ST_ADDR : ST_IDLE;
      busy_d     = start_det;
      bit_cnt_d  = 3'd7;
      bit_pend_d = 1'b0;
      sda_oe_d   = 1'b0;
      extra_d    = 1'b0;
    end else if (rx_st && scl_rise) begin
      shift_d    = {shift_q[6:0], sda_s};
      bit_pend_d = 1'b1;
    end else if (rx_st && scl_fall && bit_pend_q) begin
      bit_pend_d = 1'b0;
      if (bit_cnt_q != 3'd0) begin
        bit_cnt_d = bit_cnt_q - 3'd1;
      end else begin
        bit_cnt_d = 3'd7;
        case (state_q)
          ST_ADDR: begin
            state_d = ST_A_ACK;
            if (shift_q == SLAVE_ADDR) begin
              sda_oe_d = 1'b1;
            end else begin
              busy_d = 1'b0;
            end
          end
          ST_CMD: begin
            state_d = ST_C_ACK;
            if (shift_q == CMD_WRITE_DAC) begin
              sda_oe_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end
          ST_MSB: begin
            state_d  = ST_M_ACK;
            msb_d    = shift_q;
            sda_oe_d = 1'b1;
          end
          ST_LSB: begin
            state_d  = ST_L_ACK;
            code_d   = dac_code(msb_q, shift_q[7:4]);
            valid_d  = 1'b1;
            sda_oe_d = 1'b1;
          end
          default: begin
            // Trailing byte: NACKed through the L_ACK clock and flagged.
            state_d = ST_L_ACK;
            ferr_d  = 1'b1;
          end
        endcase
      end
    end else if (ack_st && scl_fall) begin
      sda_oe_d   = 1'b0;
      bit_cnt_d  = 3'd7;
      bit_pend_d = 1'b0;
      case (state_q)
        ST_A_ACK: state_d = sda_oe_q ? ST_CMD : ST_WAIT_STOP;
        ST_C_ACK: state_d = sda_oe_q ? ST_MSB : ST_WAIT_STOP;
        ST_M_ACK: state_d = ST_LSB;
        default: begin
          state_d = ST_WAIT_STOP;
          extra_d = 1'b1;
        end
      endcase
    end
  end

  assign I2C_SDAT  = sda_oe_q ? 1'b0 : 1'bz;
  assign DAC_CODE  = code_q;
  assign DAC_VALID = valid_q;
  assign FRAME_ERR = ferr_q;
  assign BUSY      = busy_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_i2c_dac_responder.sv
// Bus-functional 400 kHz I2C master with an SDA pull-up driving the DAC
// responder; a frame-level reference model predicts ACKs, strobes and codes.
`timescale 1ns/1ps
module tb_i2c_dac_responder;
  import i2c_dac_pkg::*;

  localparam int TQ = 625;  // quarter of a 2.5 us SCL period

  // ---------------- clock / reset ----------------
  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        scl     = 1'b1;
  logic        sda_low = 1'b0;
  wire         sda_bus;
  logic [11:0] dac_code;
  logic        dac_valid;
  logic        frame_err;
  logic        busy;
  state_e      dbg_state;

  always #10 clk = ~clk;

  assign sda_bus = sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_dac_responder dut (
    .CLOCK_50  (clk),
    .iRST_N    (rst_n),
    .I2C_SCLK  (scl),
    .I2C_SDAT  (sda_bus),
    .DAC_CODE  (dac_code),
    .DAC_VALID (dac_valid),
    .FRAME_ERR (frame_err),
    .BUSY      (busy),
    .DBG_STATE (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          checks    = 0;
  int          errors    = 0;
  int          valid_cnt = 0;
  int          ferr_cnt  = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_code  = 12'h000;
  logic        exp_ack[5];
  int          exp_valid;
  int          exp_ferr;
  logic        exp_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cnt++;
    if (dac_valid === 1'b1) begin
      logic [11:0] e;
      valid_cnt++;
      e = 12'hxxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check("strobe_code", 32'(dac_code), 32'(e));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame-level model: phase 0 addr, 1 cmd, 2 msb, 3 lsb, 4 after a good frame, 5 ignored.
  task automatic model_frame(input logic [7:0] fb[5], input int n, input int pb);
    int         phase;
    logic [7:0] msb;
    phase = 0; msb = 8'h00;
    exp_valid = 0; exp_ferr = 0; exp_busy = 1'b1;
    for (int k = 0; k < n; k++) begin
      exp_ack[k] = 1'b0;
      case (phase)
        0: if (fb[k] == 8'hC0) begin exp_ack[k] = 1'b1; phase = 1; end
           else begin phase = 5; exp_busy = 1'b0; end
        1: if (fb[k] == 8'h40) begin exp_ack[k] = 1'b1; phase = 2; end
           else begin exp_ferr++; phase = 5; end
        2: begin exp_ack[k] = 1'b1; msb = fb[k]; phase = 3; end
        3: begin
          exp_ack[k] = 1'b1;
          exp_code   = {msb, fb[k][7:4]};
          exp_q.push_back(exp_code);
          exp_valid++;
          phase = 4;
        end
        4: exp_ferr++;
        default: ;
      endcase
    end
    if (pb > 0 && phase <= 3) exp_ferr++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic i2c_start();
    sda_low = 1'b0; #TQ;
    scl = 1'b1;     #TQ;
    sda_low = 1'b1; #TQ;
    scl = 1'b0;     #TQ;
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; #TQ;
    scl = 1'b1;     #TQ;
    sda_low = 1'b0; #(2*TQ);
  endtask

  task automatic send_bit(input logic b);
    sda_low = ~b; #TQ;
    scl = 1'b1;   #(2*TQ);
    scl = 1'b0;   #TQ;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_low = 1'b0; #TQ;
    scl = 1'b1;     #TQ;
    ack = (sda_bus === 1'b0);
    #TQ;
    scl = 1'b0;     #TQ;
  endtask

  task automatic run_frame(input string tag, input int n,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4,
                           input int pb, input bit rstart);
    logic [7:0] fb[5];
    logic       ack;
    int         v0, f0;
    fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3; fb[4] = b4;
    model_frame(fb, n, pb);
    v0 = valid_cnt; f0 = ferr_cnt;
    i2c_start();
    for (int k = 0; k < n; k++) begin
      send_byte(fb[k], ack);
      check($sformatf("%s_ack%0d", tag, k), 32'(ack), 32'(exp_ack[k]));
    end
    for (int k = 0; k < pb; k++) send_bit($urandom_range(0, 1) == 1);
    check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    if (!rstart) begin
      i2c_stop();
      check({tag, "_busy_after_stop"}, 32'(busy), 32'd0);
    end
    check({tag, "_valid_pulses"}, 32'(valid_cnt - v0), 32'(exp_valid));
    check({tag, "_ferr_pulses"}, 32'(ferr_cnt - f0), 32'(exp_ferr));
    check({tag, "_code"}, 32'(dac_code), 32'(exp_code));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sda"},   32'(sda_bus),   32'd1);
    check({tag, "_code"},  32'(dac_code),  32'd0);
    check({tag, "_valid"}, 32'(dac_valid), 32'd0);
    check({tag, "_ferr"},  32'(frame_err), 32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic ack;
    int   v0, f0, n, pb;
    logic [7:0] a, c;

    repeat (5) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    run_frame("t1_full",      4, 8'hC0, 8'h40, 8'hAB, 8'hCD, 8'h00, 0, 1'b0);
    run_frame("t2_addr_miss", 1, 8'hC2, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0);
    run_frame("t3_bad_cmd",   2, 8'hC0, 8'h41, 8'h00, 8'h00, 8'h00, 0, 1'b0);
    run_frame("t4_abort",     3, 8'hC0, 8'h40, 8'h12, 8'h00, 8'h00, 3, 1'b0);
    run_frame("t4_full",      4, 8'hC0, 8'h40, 8'hFF, 8'hF0, 8'h00, 0, 1'b0);
    run_frame("t5_rstart",    3, 8'hC0, 8'h40, 8'h55, 8'h00, 8'h00, 0, 1'b1);
    run_frame("t5_full",      4, 8'hC0, 8'h40, 8'h00, 8'h10, 8'h00, 0, 1'b0);
    run_frame("extra_byte",   5, 8'hC0, 8'h40, 8'h12, 8'h34, 8'h99, 0, 1'b0);

    // Reset asserted while the responder holds the MSB ACK low.
    v0 = valid_cnt; f0 = ferr_cnt;
    i2c_start();
    send_byte(8'hC0, ack); check("t6_ack0", 32'(ack), 32'd1);
    send_byte(8'h40, ack); check("t6_ack1", 32'(ack), 32'd1);
    for (int i = 7; i >= 0; i--) send_bit(i[0]);
    sda_low = 1'b0;
    #100;
    check("t6_ack_driven", 32'(sda_bus), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("t6_reset");
    exp_code = 12'h000;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    scl = 1'b1; #(2*TQ);
    scl = 1'b0; #TQ;
    i2c_stop();
    check("t6_valid_pulses", 32'(valid_cnt - v0), 32'd0);
    check("t6_ferr_pulses",  32'(ferr_cnt - f0),  32'd0);
    run_frame("t6_full", 4, 8'hC0, 8'h40, 8'h7E, 8'h93, 8'h00, 0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'hC0;
      c  = ($urandom_range(0, 3) == 0) ? 8'h41 : 8'h40;
      n  = $urandom_range(1, 5);
      pb = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      run_frame($sformatf("rand%0d", r), n, a, c, 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), pb, 1'b0);
    end

    check("strobe_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
